// File: rtl/cal_eep_spi_responder_pkg.sv
// Shared types and frame constants for the calibration-EEPROM SPI responder.
package cal_eep_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  localparam logic [1:0] OP_WR      = 2'b01;
  localparam logic [1:0] OP_RD      = 2'b00;
  localparam int         FRAME_BITS = 16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  function automatic logic [15:0] rd_frame(input logic [7:0] data);
    return {8'h00, data};
  endfunction

endpackage

// File: rtl/cal_eep_spi_responder_if.sv
// SPI wires between the command/config master and the calibration-store responder.
interface cal_eep_spi_responder_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, SCLK, MOSI, input MISO);
  modport slave  (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/cal_eep_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one async input with rise/fall pulses in the clk domain.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/cal_eep_spi_responder.sv
// SPI mode-0 target holding the 64x8 calibration store; 16-bit write/read frames,
// read data returned on the following frame.
module cal_eep_spi_responder
  import cal_eep_pkg::*;
#(
  parameter int         ADDR_W      = 6,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] INIT_VAL    = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  cal_eep_spi_responder_if.slave  spi,
  output logic                    wr_done,
  output logic                    frame_err,
  output logic                    rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Select is synchronised active-high so every synchronizer resets to 0 (idle).
  logic [2:0] raw, lvl, rise, fall;
  assign raw = {~spi.SS_n, spi.SCLK, spi.MOSI};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (raw[g]),
      .q    (lvl[g]),
      .rise (rise[g]),
      .fall (fall[g])
    );
  end

  logic sel, ss_fall, ss_rise, sclk_rise, sclk_fall, mosi;
  assign sel       = lvl[2];
  assign ss_fall   = rise[2];
  assign ss_rise   = fall[2];
  assign sclk_rise = rise[1];
  assign sclk_fall = fall[1];
  assign mosi      = lvl[0];

  logic unused_sync;
  assign unused_sync = &{lvl[1], rise[0], fall[0]};

  state_t              state;
  logic [4:0]          bit_cnt;
  logic [15:0]         rx_shft, tx_shft, tx_load;
  logic [7:0]          rd_data;
  logic                miso;
  logic                armed;
  logic [SYNC_STAGES:0] vld_pipe;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   addr;
  logic [1:0]          op;
  logic                len_ok;

  assign addr    = rx_shft[8 +: ADDR_W];
  assign op      = rx_shft[15:14];
  assign len_ok  = (bit_cnt == 5'(FRAME_BITS));
  assign tx_load = rd_valid ? rd_frame(rd_data) : 16'h0000;

  assign wr_done   = (state == DECODE) && len_ok && (op == OP_WR);
  assign frame_err = (state == DECODE) && (!len_ok || op[1]);
  assign spi.MISO  = miso;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shft  <= '0;
      tx_shft  <= '0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
      miso     <= 1'b0;
      armed    <= 1'b0;
      vld_pipe <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else begin
      // Until the synchronizers refill after reset and SS_n is seen high,
      // a low select belongs to an aborted frame and must not start a new one.
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      if (vld_pipe[SYNC_STAGES] && !sel) armed <= 1'b1;

      case (state)
        IDLE: begin
          miso <= 1'b0;
          if (ss_fall && armed) begin
            state    <= SHIFT;
            tx_shft  <= tx_load;
            miso     <= tx_load[15];
            bit_cnt  <= '0;
            rx_shft  <= '0;
            rd_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_shft <= {rx_shft[14:0], mosi};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
          end
          if (sclk_fall) begin
            tx_shft <= {tx_shft[14:0], 1'b0};
            miso    <= tx_shft[14];
          end
          if (ss_rise) begin
            state <= DECODE;
            miso  <= 1'b0;
          end
        end
        DECODE: begin
          state <= IDLE;
          miso  <= 1'b0;
          if (len_ok) begin
            if (op == OP_WR) begin
              mem[addr] <= rx_shft[7:0];
              rd_valid  <= 1'b0;
            end else if (op == OP_RD) begin
              rd_data  <= mem[addr];
              rd_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
